// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants and state encoding for the FFT-to-UART sequencer
//
// Holds the frame geometry (result words, word and byte widths, bytes per
// frame and the byte index width) and the sequencer state encoding.

package fft_pkg;

    localparam int N_POINTS    = 32;
    localparam int WORD_SIZE   = 16;
    localparam int DATA_LENGTH = 8;

    // Each result word goes out as two bytes, low byte first.
    localparam int BYTE_COUNT  = 2 * N_POINTS;
    localparam int IDX_W       = $clog2(BYTE_COUNT);
    localparam int WORD_IDX_W  = $clog2(N_POINTS);
    localparam int RESULTS_W   = N_POINTS * WORD_SIZE;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_WAIT_TX = 3'd4
    } state_t;

    // Odd byte indices carry the upper half of a result word.
    function automatic logic [DATA_LENGTH-1:0] word_byte(
        input logic [WORD_SIZE-1:0] word,
        input logic                 high
    );
        return high ? word[WORD_SIZE-1 -: DATA_LENGTH] : word[DATA_LENGTH-1:0];
    endfunction

endpackage

// File: rtl/fft_uart_tx_sequencer_byte_select.sv
// rtl/fft_uart_tx_sequencer_byte_select.sv - snapshot word/byte mux indexed by byte index
//
// Ports:
//   i_snapshot  captured FFT results, word k at [k*WORD_SIZE +: WORD_SIZE]
//   i_idx       frame byte index; word = i_idx>>1, i_idx[0] selects high byte
//   o_byte      selected byte, purely combinational

module fft_uart_tx_sequencer_byte_select
    import fft_pkg::*;
(
    input  logic [RESULTS_W-1:0]   i_snapshot,
    input  logic [IDX_W-1:0]       i_idx,
    output logic [DATA_LENGTH-1:0] o_byte
);

    logic [WORD_SIZE-1:0]  words [N_POINTS];
    logic [WORD_IDX_W-1:0] word_idx;
    logic [WORD_SIZE-1:0]  word;

    for (genvar k = 0; k < N_POINTS; k++) begin : g_words
        assign words[k] = i_snapshot[k*WORD_SIZE +: WORD_SIZE];
    end

    assign word_idx = i_idx[IDX_W-1:1];
    assign word     = words[word_idx];
    assign o_byte   = word_byte(word, i_idx[0]);

endmodule

// File: rtl/fft_uart_tx_sequencer.sv
// rtl/fft_uart_tx_sequencer.sv - sequences UART_RX trigger, FFT run and UART_TX frame output
//
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_rx_valid     byte received pulse; starts an FFT run from IDLE
//   i_fft_done     FFT done level; its rising edge ends the run
//   i_results      flattened FFT real outputs, captured on run completion
//   i_tx_done      UART_TX byte finished pulse
//   o_fft_run      FFT enable (core reset = ~o_fft_run)
//   o_tx_start     one-cycle transmit request for o_tx_byte
//   o_tx_byte      byte under transmission, from the snapshot
//   o_tx_active    UART_TX enable for the duration of the frame
//   o_byte_idx     index of the byte under transmission
//   o_busy         any state other than IDLE
//   o_frame_done   pulse after the last byte is acknowledged
//   o_error        pulse when the TX watchdog aborts the frame

module fft_uart_tx_sequencer
    import fft_pkg::*;
#(
    parameter int TX_TIMEOUT = 20000
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_rx_valid,
    input  logic                   i_fft_done,
    input  logic [RESULTS_W-1:0]   i_results,
    input  logic                   i_tx_done,
    output logic                   o_fft_run,
    output logic                   o_tx_start,
    output logic [DATA_LENGTH-1:0] o_tx_byte,
    output logic                   o_tx_active,
    output logic [IDX_W-1:0]       o_byte_idx,
    output logic                   o_busy,
    output logic                   o_frame_done,
    output logic                   o_error
);

    // Watchdog counts 0..TX_TIMEOUT-1, so $clog2(TX_TIMEOUT) bits suffice.
    localparam int              WD_W     = $clog2(TX_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TX_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_COUNT - 1);

    state_t               state;
    state_t               state_next;
    logic [RESULTS_W-1:0] snapshot;
    logic [IDX_W-1:0]     idx;
    logic [WD_W-1:0]      wd_cnt;
    logic                 fft_done_prev;
    logic                 fft_rise;
    logic                 frame_done_q;
    logic                 error_q;
    logic                 last_byte;
    logic                 wd_expired;

    assign last_byte  = (idx == LAST_IDX);
    assign wd_expired = (wd_cnt == WD_LIMIT);

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; i_tx_done has priority over the watchdog limit.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fft_rise) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: state_next = ST_SEND;
            ST_SEND:    state_next = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (i_tx_done) begin
                    state_next = last_byte ? ST_IDLE : ST_SEND;
                end else if (wd_expired) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state so that reset drops them immediately.
    always_comb begin
        o_fft_run   = 1'b0;
        o_tx_start  = 1'b0;
        o_tx_active = 1'b0;
        o_busy      = (state != ST_IDLE);
        case (state)
            ST_RUN:     o_fft_run = 1'b1;
            ST_SEND: begin
                o_tx_start  = 1'b1;
                o_tx_active = 1'b1;
            end
            ST_WAIT_TX: o_tx_active = 1'b1;
            default: ;
        endcase
    end

    // Datapath: done-edge detector, snapshot, byte index, watchdog, pulses.
    // The edge is registered so fft_done_prev tracks the level in every
    // state; a level held high across frames never looks like a new edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fft_done_prev <= 1'b0;
            fft_rise      <= 1'b0;
            snapshot      <= '0;
            idx           <= '0;
            wd_cnt        <= '0;
            frame_done_q  <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            fft_done_prev <= i_fft_done;
            fft_rise      <= i_fft_done & ~fft_done_prev;
            frame_done_q  <= 1'b0;
            error_q       <= 1'b0;
            case (state)
                ST_CAPTURE: begin
                    snapshot <= i_results;
                    idx      <= '0;
                end
                ST_SEND: begin
                    wd_cnt <= '0;
                end
                ST_WAIT_TX: begin
                    if (i_tx_done) begin
                        if (last_byte) begin
                            frame_done_q <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else if (wd_expired) begin
                        error_q <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    fft_uart_tx_sequencer_byte_select u_byte_select (
        .i_snapshot (snapshot),
        .i_idx      (idx),
        .o_byte     (o_tx_byte)
    );

    assign o_byte_idx   = idx;
    assign o_frame_done = frame_done_q;
    assign o_error      = error_q;

endmodule

// File: tb/tb_fft_uart_tx_sequencer.sv
// tb/tb_fft_uart_tx_sequencer.sv - directed self-checking bench for fft_uart_tx_sequencer

module tb_fft_uart_tx_sequencer;
    import fft_pkg::*;

    localparam int TX_TIMEOUT = 20000;
    localparam int TX_GAP     = 50;
    localparam int START_WAIT = 10;

    logic                   i_clk = 1'b0;
    logic                   i_rst;
    logic                   i_rx_valid;
    logic                   i_fft_done;
    logic [RESULTS_W-1:0]   i_results;
    logic                   i_tx_done;
    logic                   o_fft_run;
    logic                   o_tx_start;
    logic [DATA_LENGTH-1:0] o_tx_byte;
    logic                   o_tx_active;
    logic [IDX_W-1:0]       o_byte_idx;
    logic                   o_busy;
    logic                   o_frame_done;
    logic                   o_error;

    int tests_run    = 0;
    int tests_failed = 0;

    int start_total = 0;
    int frame_total = 0;
    int error_total = 0;
    int run_rise    = 0;
    logic run_q     = 1'b0;

    logic [7:0] obs [BYTE_COUNT];

    fft_uart_tx_sequencer #(.TX_TIMEOUT(TX_TIMEOUT)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rx_valid   (i_rx_valid),
        .i_fft_done   (i_fft_done),
        .i_results    (i_results),
        .i_tx_done    (i_tx_done),
        .o_fft_run    (o_fft_run),
        .o_tx_start   (o_tx_start),
        .o_tx_byte    (o_tx_byte),
        .o_tx_active  (o_tx_active),
        .o_byte_idx   (o_byte_idx),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_error      (o_error)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_tx_start)            start_total++;
        if (o_frame_done)          frame_total++;
        if (o_error)               error_total++;
        if (o_fft_run && !run_q)   run_rise++;
        run_q = o_fft_run;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [15:0] exp_word(input int pat, input int k);
        logic [15:0] w;
        if (k == 0)       w = 16'h1234;
        else if (k == 31) w = 16'hABCD;
        else              w = {8'(k) + 8'h40, 8'hC0 - 8'(k)};
        if (pat == 1) w = w ^ 16'h5A5A;
        return w;
    endfunction

    function automatic logic [7:0] exp_byte(input int pat, input int b);
        logic [15:0] w;
        w = exp_word(pat, b / 2);
        return (b % 2 == 1) ? w[15:8] : w[7:0];
    endfunction

    function automatic logic [RESULTS_W-1:0] build_results(input int pat);
        logic [RESULTS_W-1:0] r;
        for (int k = 0; k < N_POINTS; k++) r[k*WORD_SIZE +: WORD_SIZE] = exp_word(pat, k);
        return r;
    endfunction

    function automatic logic [63:0] all_outputs();
        return {48'd0, o_fft_run, o_tx_start, o_tx_active, o_busy, o_frame_done, o_error,
                o_byte_idx, o_tx_byte};
    endfunction

    task automatic pulse_rx();
        i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!o_tx_start && n < START_WAIT) begin
            tick();
            n++;
        end
    endtask

    // Entered in RUN with i_fft_done low. Raises i_fft_done and plays UART_TX.
    task automatic run_frame(input int pat, input int withhold_idx, input int reset_idx,
                             input bit change_results, input bit spam_rx);
        int n;
        i_fft_done = 1'b1;
        wait_start(n);
        check_eq("start_latency", n, 3);
        for (int b = 0; b < BYTE_COUNT; b++) begin
            if (b > 0) begin
                wait_start(n);
                check_eq("next_start_latency", n + 1, 1);
            end
            obs[b] = o_tx_byte;
            check_eq("byte_idx", o_byte_idx, b);
            check_eq("tx_byte", o_tx_byte, exp_byte(pat, b));
            if (b == withhold_idx) begin
                n = 0;
                while (!o_error && n < TX_TIMEOUT + 20) begin
                    tick();
                    n++;
                end
                check_eq("error_latency", n - 1, TX_TIMEOUT);
                check_eq("error_tx_active", o_tx_active, 0);
                check_eq("error_busy", o_busy, 0);
                tick();
                check_eq("error_one_cycle", o_error, 0);
                return;
            end
            if (b == reset_idx) begin
                tick();
                check_eq("pre_reset_wait_tx", {o_tx_active, o_tx_start}, 2'b10);
                i_rst = 1'b1;
                #1;
                check_eq("reset_async_outputs", all_outputs(), 0);
                tick();
                check_eq("reset_next_cycle", all_outputs(), 0);
                i_rst = 1'b0;
                return;
            end
            for (int k = 1; k <= TX_GAP; k++) begin
                i_rx_valid = spam_rx && (k == 20);
                if (change_results && k == 10) i_results = '1;
                tick();
            end
            i_rx_valid = 1'b0;
            i_tx_done  = 1'b1;
            tick();
            i_tx_done  = 1'b0;
        end
        check_eq("frame_done_pulse", o_frame_done, 1);
        check_eq("frame_end_tx_active", o_tx_active, 0);
        check_eq("frame_end_busy", o_busy, 0);
        tick();
        check_eq("frame_done_one_cycle", o_frame_done, 0);
    endtask

    initial begin
        int s0, f0, e0, r0;
        i_rst      = 1'b1;
        i_rx_valid = 1'b0;
        i_fft_done = 1'b0;
        i_results  = '0;
        i_tx_done  = 1'b0;
        tick();
        tick();
        check_eq("reset_outputs", all_outputs(), 0);
        i_rst = 1'b0;
        tick();
        check_eq("idle_after_reset", all_outputs(), 0);

        // tx_done in IDLE is ignored
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        check_eq("idle_ignores_tx_done", {o_busy, o_byte_idx}, 0);

        // Frame A: full frame, results changed after capture, rx spam in RUN and WAIT_TX
        s0 = start_total; f0 = frame_total; e0 = error_total; r0 = run_rise;
        i_results = build_results(0);
        pulse_rx();
        check_eq("run_after_rx", {o_fft_run, o_busy}, 2'b11);
        pulse_rx();
        tick();
        pulse_rx();
        check_eq("run_ignores_rx", {o_fft_run, o_tx_active}, 2'b10);
        run_frame(0, -1, -1, 1'b1, 1'b1);
        check_eq("frameA_byte0", obs[0], 8'h34);
        check_eq("frameA_byte1", obs[1], 8'h12);
        check_eq("frameA_byte62", obs[62], 8'hCD);
        check_eq("frameA_byte63", obs[63], 8'hAB);
        check_eq("frameA_start_count", start_total - s0, 64);
        check_eq("frameA_frame_done_count", frame_total - f0, 1);
        check_eq("frameA_error_count", error_total - e0, 0);
        check_eq("frameA_run_assertions", run_rise - r0, 1);

        // Frame B: i_fft_done still high from frame A, so no capture until it toggles
        s0 = start_total; e0 = error_total;
        i_results = build_results(1);
        pulse_rx();
        for (int k = 0; k < 20; k++) tick();
        check_eq("held_high_no_capture", {o_fft_run, o_tx_active}, 2'b10);
        check_eq("held_high_no_start", start_total - s0, 0);
        i_fft_done = 1'b0;
        tick();
        run_frame(1, 5, -1, 1'b0, 1'b0);
        check_eq("frameB_start_count", start_total - s0, 6);
        check_eq("frameB_error_count", error_total - e0, 1);
        check_eq("frameB_idle", {o_busy, o_fft_run}, 0);

        // Frame C: asynchronous reset while waiting on byte 10
        i_fft_done = 1'b0;
        i_results  = build_results(0);
        pulse_rx();
        tick();
        run_frame(0, -1, 10, 1'b0, 1'b0);
        i_fft_done = 1'b0;
        pulse_rx();
        check_eq("run_after_reset", {o_fft_run, o_busy, o_byte_idx}, {2'b11, 6'd0});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
